// File: rtl/rgb_ctrl_pkg.sv
// Shared constants, frame payload layout and channel step helper for the RGB fade controller.
package rgb_ctrl_pkg;

   localparam int unsigned FRAME_W = 16;
   localparam int unsigned CHAN_W  = 8;
   localparam int unsigned N_CHAN  = 3;

   localparam logic [7:0] ADDR_R    = 8'd1;
   localparam logic [7:0] ADDR_G    = 8'd2;
   localparam logic [7:0] ADDR_B    = 8'd3;
   localparam logic [7:0] ADDR_STEP = 8'd4;
   localparam logic [7:0] ADDR_SNAP = 8'd5;
   localparam logic [7:0] ADDR_MODE = 8'd6;

   typedef struct packed {
      logic [7:0]        addr;
      logic [CHAN_W-1:0] val;
   } frame_t;

   // Move one LSB toward the target, holding once reached.
   function automatic logic [CHAN_W-1:0] step_toward(input logic [CHAN_W-1:0] cur,
                                                     input logic [CHAN_W-1:0] tgt);
      logic [CHAN_W-1:0] nxt;
      nxt = cur;
      if (cur < tgt)
         nxt = cur + CHAN_W'(1);
      else if (cur > tgt)
         nxt = cur - CHAN_W'(1);
      return nxt;
   endfunction

endpackage

// File: rtl/rgb_frame_rx.sv
// Serial frame receiver: LSB-first shift while enable is high, commit on the
// registered falling edge of enable, flag frames that are not exactly FRAME_W bits.
module rgb_frame_rx
   import rgb_ctrl_pkg::*;
(
   input  logic   clk,
   input  logic   rst,
   input  logic   enable,
   input  logic   data,
   output logic   frame_valid_c,
   output frame_t frame,
   output logic   frame_err
);

   localparam int unsigned IDX_W = 5;
   localparam logic [IDX_W-1:0] IDX_FULL = IDX_W'(FRAME_W);
   localparam logic [IDX_W-1:0] IDX_SAT  = IDX_W'(FRAME_W + 1);

   logic [IDX_W-1:0]   idx;
   logic [FRAME_W-1:0] shift;
   logic               en_d;
   logic               commit_c;

   assign commit_c      = en_d & ~enable;
   assign frame_valid_c = commit_c & (idx == IDX_FULL);
   assign frame         = frame_t'(shift);

   // Bit index saturates one past a full frame so overlong frames stay detectable.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         idx       <= '0;
         shift     <= '0;
         en_d      <= 1'b0;
         frame_err <= 1'b0;
      end else begin
         en_d      <= enable;
         frame_err <= commit_c & (idx != IDX_FULL);
         if (enable) begin
            if (idx < IDX_FULL)
               shift[idx[3:0]] <= data;
            if (idx != IDX_SAT)
               idx <= idx + IDX_W'(1);
         end else if (commit_c) begin
            idx <= '0;
         end
      end
   end

endmodule

// File: rtl/rgb_fade_ctrl.sv
// RGB fade controller: decodes serial command frames into per-channel targets
// and ramps each PWM duty value toward its target one LSB per fade tick.
module rgb_fade_ctrl
   import rgb_ctrl_pkg::*;
#(
   parameter int unsigned TICK_SHIFT = 8,
   parameter logic [7:0]  RESET_VAL  = 8'd255
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              enable,
   input  logic              data,
   output logic [CHAN_W-1:0] pwm_val_r,
   output logic [CHAN_W-1:0] pwm_val_g,
   output logic [CHAN_W-1:0] pwm_val_b,
   output logic              pwm_en,
   output logic              busy,
   output logic              frame_err
);

   localparam int unsigned CNT_W = 8 + TICK_SHIFT + 1;

   logic                          frame_valid_c;
   frame_t                        frame;
   logic [1:0]                    ch_c;

   logic [N_CHAN-1:0][CHAN_W-1:0] val_q, val_d;
   logic [N_CHAN-1:0][CHAN_W-1:0] tgt_q, tgt_d;
   logic [7:0]                    step_div_q, step_div_d;
   logic                          fade_on_q, fade_on_d;
   logic [CNT_W-1:0]              cnt_q, cnt_d;
   logic [CNT_W-1:0]              cnt_lim_c;
   logic                          tick_c;

   rgb_frame_rx u_rx (
      .clk           (clk),
      .rst           (rst),
      .enable        (enable),
      .data          (data),
      .frame_valid_c (frame_valid_c),
      .frame         (frame),
      .frame_err     (frame_err)
   );

   assign cnt_lim_c = CNT_W'((CNT_W'(step_div_q) + CNT_W'(1)) << TICK_SHIFT) - CNT_W'(1);
   assign tick_c    = (cnt_q == cnt_lim_c);
   assign ch_c      = 2'(frame.addr[1:0] - 2'd1);

   // Tick step first; a committed frame then overrides the channels it writes.
   always_comb begin
      val_d      = val_q;
      tgt_d      = tgt_q;
      step_div_d = step_div_q;
      fade_on_d  = fade_on_q;
      cnt_d      = tick_c ? '0 : cnt_q + CNT_W'(1);

      if (tick_c && fade_on_q) begin
         for (int i = 0; i < int'(N_CHAN); i++)
            val_d[i] = step_toward(val_q[i], tgt_q[i]);
      end

      if (frame_valid_c) begin
         case (frame.addr)
            ADDR_R, ADDR_G, ADDR_B: begin
               tgt_d[ch_c] = frame.val;
               if (!fade_on_q)
                  val_d[ch_c] = frame.val;
            end
            ADDR_STEP: begin
               step_div_d = frame.val;
               cnt_d      = '0;
            end
            ADDR_SNAP: begin
               val_d = tgt_q;
            end
            ADDR_MODE: begin
               fade_on_d = frame.val[0];
               if (!frame.val[0])
                  val_d = tgt_q;
            end
            default: begin
            end
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         val_q      <= {N_CHAN{RESET_VAL}};
         tgt_q      <= {N_CHAN{RESET_VAL}};
         step_div_q <= '0;
         fade_on_q  <= 1'b0;
         cnt_q      <= '0;
         pwm_en     <= 1'b0;
      end else begin
         val_q      <= val_d;
         tgt_q      <= tgt_d;
         step_div_q <= step_div_d;
         fade_on_q  <= fade_on_d;
         cnt_q      <= cnt_d;
         pwm_en     <= ~enable;
      end
   end

   assign pwm_val_r = val_q[0];
   assign pwm_val_g = val_q[1];
   assign pwm_val_b = val_q[2];
   assign busy      = |(val_q ^ tgt_q);

endmodule

// File: tb/tb_rgb_fade_ctrl.sv
// Self-checking bench for rgb_fade_ctrl: directed scenarios plus random frames,
// compared every cycle against a frame-level reference model.
module tb_rgb_fade_ctrl;

   localparam int unsigned TS = 8;

   logic       clk = 1'b0;
   logic       rst;
   logic       enable;
   logic       data;
   logic [7:0] pwm_val_r, pwm_val_g, pwm_val_b;
   logic       pwm_en, busy, frame_err;

   int unsigned n_chk = 0;
   int unsigned n_bad = 0;

   // Reference model state
   logic [7:0]  m_val [3];
   logic [7:0]  m_tgt [3];
   logic [7:0]  m_step;
   bit          m_fade;
   int unsigned m_cyc;
   bit          m_prev_en;
   bit          m_pwm_en;
   bit          m_err;
   bit          m_bits [$];

   always #5 clk = ~clk;

   rgb_fade_ctrl #(.TICK_SHIFT(TS), .RESET_VAL(8'd255)) dut (
      .clk       (clk),
      .rst       (rst),
      .enable    (enable),
      .data      (data),
      .pwm_val_r (pwm_val_r),
      .pwm_val_g (pwm_val_g),
      .pwm_val_b (pwm_val_b),
      .pwm_en    (pwm_en),
      .busy      (busy),
      .frame_err (frame_err)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, obs, exp);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < 3; i++) begin
         m_val[i] = 8'd255;
         m_tgt[i] = 8'd255;
      end
      m_step    = 8'd0;
      m_fade    = 1'b0;
      m_cyc     = 0;
      m_prev_en = 1'b0;
      m_pwm_en  = 1'b0;
      m_err     = 1'b0;
      m_bits.delete();
   endtask

   // One clock edge of the reference model, given the inputs sampled at that edge.
   task automatic model_edge(input bit en, input bit d);
      int unsigned period;
      bit          tick;
      logic [7:0]  nv [3];
      logic [15:0] f;
      logic [7:0]  addr, v;
      period = (int'(m_step) + 1) << TS;
      tick   = ((m_cyc % period) == period - 1);
      nv     = m_val;
      m_err  = 1'b0;
      if (tick && m_fade) begin
         for (int i = 0; i < 3; i++) begin
            if (nv[i] < m_tgt[i]) nv[i] = nv[i] + 8'd1;
            else if (nv[i] > m_tgt[i]) nv[i] = nv[i] - 8'd1;
         end
      end
      m_cyc++;
      if (en) m_bits.push_back(d);
      if (m_prev_en && !en) begin
         if (m_bits.size() == 16) begin
            f = '0;
            for (int i = 0; i < 16; i++) f[i] = m_bits[i];
            addr = f[15:8];
            v    = f[7:0];
            case (int'(addr))
               1, 2, 3: begin
                  m_tgt[int'(addr) - 1] = v;
                  if (!m_fade) nv[int'(addr) - 1] = v;
               end
               4: begin
                  m_step = v;
                  m_cyc  = 0;
               end
               5: nv = m_tgt;
               6: begin
                  m_fade = v[0];
                  if (!v[0]) nv = m_tgt;
               end
               default: ;
            endcase
         end else begin
            m_err = 1'b1;
         end
         m_bits.delete();
      end
      m_val     = nv;
      m_prev_en = en;
      m_pwm_en  = !en;
   endtask

   task automatic compare_all();
      bit exp_busy;
      exp_busy = (m_val[0] != m_tgt[0]) || (m_val[1] != m_tgt[1]) || (m_val[2] != m_tgt[2]);
      chk("pwm_val_r", 32'(pwm_val_r), 32'(m_val[0]));
      chk("pwm_val_g", 32'(pwm_val_g), 32'(m_val[1]));
      chk("pwm_val_b", 32'(pwm_val_b), 32'(m_val[2]));
      chk("pwm_en",    32'(pwm_en),    32'(m_pwm_en));
      chk("busy",      32'(busy),      32'(exp_busy));
      chk("frame_err", 32'(frame_err), 32'(m_err));
   endtask

   // Drive at the falling edge, advance the model at the rising edge, check at the next falling edge.
   task automatic cycle(input bit en, input bit d);
      enable = en;
      data   = d;
      @(posedge clk);
      if (rst) model_reset();
      else model_edge(en, d);
      @(negedge clk);
      compare_all();
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cycle(1'b0, 1'b0);
   endtask

   task automatic send(input logic [31:0] bits, input int n);
      for (int i = 0; i < n; i++) cycle(1'b1, bits[i]);
      cycle(1'b0, 1'b0);
   endtask

   initial begin
      logic [31:0] bits;
      int          n, sel;

      rst    = 1'b1;
      enable = 1'b0;
      data   = 1'b0;
      model_reset();
      @(negedge clk);
      compare_all();
      idle(2);
      rst = 1'b0;
      idle(3);

      // Immediate write with fade off
      send(32'h0180, 16);
      idle(3);

      // Fade green down to 240 at the default tick rate
      send(32'h0601, 16);
      send(32'h4000, 16);
      send(32'h0400, 16);
      send(32'h02F0, 16);
      idle(16 * 256 + 40);
      chk("g_ramp_end", 32'(pwm_val_g), 32'd240);

      // Short and long frames are dropped
      send(32'h0155, 15);
      idle(2);
      send(32'h1_0133, 17);
      idle(2);

      // Snap during a ramp
      send(32'h0100, 16);
      idle(600);
      send(32'h0500, 16);
      idle(3);
      send(32'h0600, 16);
      idle(2);

      // Reset in the middle of a frame, then a clean frame
      bits = 32'h0377;
      for (int i = 0; i < 8; i++) cycle(1'b1, bits[i]);
      rst    = 1'b1;
      enable = 1'b0;
      #1;
      model_reset();
      compare_all();
      @(negedge clk);
      idle(2);
      rst = 1'b0;
      idle(2);
      send(32'h0310, 16);
      idle(3);
      chk("b_after_rst", 32'(pwm_val_b), 32'h10);

      // Randomized frames
      for (int k = 0; k < 80; k++) begin
         sel  = int'($urandom_range(0, 9));
         bits = $urandom;
         bits[15:8] = 8'($urandom_range(0, 7));
         if (bits[15:8] == 8'd4) bits[7:0] = 8'($urandom_range(0, 1));
         if (bits[15:8] == 8'd6 && $urandom_range(0, 1) == 0) bits[0] = 1'b1;
         case (sel)
            0: n = 15;
            1: n = 17;
            2: n = int'($urandom_range(1, 20));
            default: n = 16;
         endcase
         send(bits, n);
         idle(int'($urandom_range(0, 300)));
      end
      idle(20);

      $display("test done: total=%0d bad=%0d", n_chk, n_bad);
      $finish;
   end

endmodule

// File: doc/rgb_fade_ctrl.md
Name: rgb_fade_ctrl

Overview:
Configuration and sequencing controller for the three 8-bit RGB PWM channels. Receives 16-bit serial command frames on enable/data, decodes them into per-channel target registers, and ramps each pwm_val output toward its target one LSB per fade tick. Sits between the external serial interface and the three pwm instances, and drives their shared enable.

Parameters:
TICK_SHIFT, 8, fade tick period = (step_div+1) << TICK_SHIFT clk cycles
RESET_VAL, 255, reset value of all pwm_val outputs and targets

Ports:
clk  input  1  system clock
rst  input  1  asynchronous active-high reset
enable  input  1  frame strobe; high while a frame is shifted in
data  input  1  serial data, sampled on posedge clk while enable=1, LSB first
pwm_val_r  output  8  red PWM duty value
pwm_val_g  output  8  green PWM duty value
pwm_val_b  output  8  blue PWM duty value
pwm_en  output  1  enable to all pwm instances
busy  output  1  high while any channel value differs from its target
frame_err  output  1  one-cycle pulse when a frame is discarded

Behaviour:
- Reset (async, rst=1): pwm_val_*=RESET_VAL, targets=RESET_VAL, step_div=0, fade_on=0, tick counter=0, bit index=0, shift reg=0, pwm_en=0, busy=0, frame_err=0.
- Receive: each clk with enable=1: shift[idx] <= data; idx increments and saturates at 17 (overflow flag). pwm_en <= 0 while enable=1, and <= 1 on every cycle with enable=0 (1-cycle registered latency).
- Commit: on the first cycle with enable=0 after enable=1 (registered falling edge): if exactly 16 bits received, decode frame; otherwise drop it and pulse frame_err for 1 cycle. idx clears to 0 in that cycle.
- Decode (addr=shift[15:8], val=shift[7:0]):
  1/2/3: target R/G/B <= val; if fade_on=0, the corresponding pwm_val is also <= val in the same cycle.
  4: step_div <= val; tick counter clears to 0.
  5: snap: pwm_val_* <= current targets.
  6: fade_on <= val[0]; when cleared, pwm_val_* snap to targets.
  Any other addr: ignored, no error.
- Fade tick: free-running counter; tick asserts for 1 cycle when count == ((step_div+1)<<TICK_SHIFT)-1, then wraps to 0. Counter width = 8+TICK_SHIFT+1.
- On tick with fade_on=1: each channel independently: value<target -> +1; value>target -> -1; equal -> hold. No wrap; a channel reaches its target and stops.
- Same-cycle tick and commit: a commit writing pwm_val (addr 1–3 with fade_on=0, addr 5, addr 6) overrides the tick step for that channel. A target write (addr 1–3) with fade_on=1 makes the tick step toward the old target this cycle and the new target afterwards.
- busy: combinational OR over the channels of (pwm_val != target).
- Reset mid-frame: partial frame discarded, no frame_err.

Decomposition:
- Package rgb_ctrl_pkg: address constants ADDR_R=1, ADDR_G=2, ADDR_B=3, ADDR_STEP=4, ADDR_SNAP=5, ADDR_MODE=6; FRAME_W=16.
- Sub-module rgb_frame_rx: serial shift, bit counter, falling-edge detect. Outputs frame_valid pulse, frame[15:0] and frame_err. The top handles decode, target/value registers and the fade tick.

Test Plan:
- Reset, then idle -> pwm_val_*=255, pwm_en=1 one cycle after rst deasserts, busy=0.
- fade_on=0, frame 0x0180 -> pwm_val_r=0x80 on the cycle after the commit; pwm_en=0 during the 16 shift cycles; busy stays 0.
- Frames 0x0601, 0x4000, 0x02F0 -> pwm_val_g decrements 255→240 one step per 256 clks; busy deasserts exactly when it reaches 240.
- 15-bit and 17-bit frames -> frame_err pulses once for each; all registers unchanged.
- fade_on=1 with ramp in progress, frame 0x0500 -> all pwm_val equal targets the next cycle; busy=0.
- rst asserted during bit 8 of a frame, then a full 0x0310 frame -> pwm_val_b=0x10 with fade_on=0; no frame_err.
